// File: rtl/pendulum_drive_sequencer.sv
// Pendulum actuator sequencer: tracks encoder position, latches swing amplitude at
// reversals, and fires one timed Drive/Load window per zero crossing (or a kick when stalled).
module pendulum_drive_sequencer #(
  parameter int CNT_W    = 12,
  parameter int TICK_DIV = 4000,
  parameter int STALL_MS = 500
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             enc_step,
  input  logic             enc_dir,
  input  logic [2:0]       R,
  input  logic [CNT_W-1:0] amp_limit,
  output logic             drive,
  output logic             load,
  output logic             drive_dir,
  output logic [CNT_W-1:0] amplitude,
  output logic [2:0]       state,
  output logic             busy
);
  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int STALL_W = $clog2(STALL_MS + 1);
  localparam logic [CNT_W-1:0] POS_MIN = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] POS_MAX = {1'b0, {(CNT_W-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_DRIVE = 3'd2,
    S_LOAD  = 3'd3,
    S_COOL  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   pos_q, pos_d;
  logic               last_dir_q, last_dir_d;
  logic [CNT_W-1:0]   amp_q, amp_d;
  logic [TICK_W-1:0]  presc_q, presc_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [2:0]         win_q, win_d;
  logic               dir_q, dir_d;

  logic [CNT_W-1:0] pos_step, pos_abs;
  logic             zero_x, rev, tick, stall_hit, kick, enter;

  assign pos_step  = enc_dir ? pos_q + CNT_W'(1) : pos_q - CNT_W'(1);
  assign zero_x    = enc_step && (pos_step == '0);
  assign rev       = enc_step && (enc_dir != last_dir_q);
  assign tick      = (presc_q == TICK_W'(TICK_DIV - 1));
  assign stall_hit = (stall_q == STALL_W'(STALL_MS));
  // The most negative position has no positive twin; clamp it to the largest magnitude.
  assign pos_abs   = !pos_q[CNT_W-1] ? pos_q :
                     (pos_q == POS_MIN) ? POS_MAX : (~pos_q + CNT_W'(1));

  always_comb begin
    state_d    = state_q;
    pos_d      = enc_step ? pos_step : pos_q;
    last_dir_d = enc_step ? enc_dir : last_dir_q;
    amp_d      = rev ? pos_abs : amp_q;
    presc_d    = tick ? '0 : presc_q + TICK_W'(1);
    stall_d    = enc_step ? '0 :
                 (tick && !stall_hit) ? stall_q + STALL_W'(1) : stall_q;
    win_d      = win_q;
    dir_d      = dir_q;
    kick       = 1'b0;
    enter      = 1'b0;

    if (!en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_ARMED;
        S_ARMED: begin
          // A crossing beats a simultaneous stall timeout.
          if (zero_x) begin
            state_d = (amp_q < amp_limit) ? S_DRIVE : S_LOAD;
            dir_d   = enc_dir;
            enter   = 1'b1;
          end else if (stall_hit) begin
            kick = 1'b1;
          end
        end
        S_DRIVE, S_LOAD: begin
          if (tick) begin
            if (win_q == 3'd0) state_d = S_COOL;
            else               win_d   = win_q - 3'd1;
          end
        end
        S_COOL: begin
          if (rev)            state_d = S_ARMED;
          else if (stall_hit) kick    = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase

      if (kick) begin
        state_d = S_DRIVE;
        dir_d   = 1'b1;
        amp_d   = '0;
        stall_d = '0;
        enter   = 1'b1;
      end
      // Restart the prescaler so the window is a whole number of ticks long.
      if (enter) begin
        presc_d = '0;
        win_d   = R;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pos_q      <= '0;
      last_dir_q <= 1'b1;
      amp_q      <= '0;
      presc_q    <= '0;
      stall_q    <= '0;
      win_q      <= '0;
      dir_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      last_dir_q <= last_dir_d;
      amp_q      <= amp_d;
      presc_q    <= presc_d;
      stall_q    <= stall_d;
      win_q      <= win_d;
      dir_q      <= dir_d;
    end
  end

  assign drive     = (state_q == S_DRIVE);
  assign load      = (state_q == S_LOAD);
  assign busy      = drive | load;
  assign drive_dir = dir_q;
  assign amplitude = amp_q;
  assign state     = state_q;
endmodule

// File: tb/tb_pendulum_drive_sequencer.sv
// Scoreboard bench for pendulum_drive_sequencer: expectations queued with stimulus,
// popped and compared as the DUT responds.
module tb_pendulum_drive_sequencer;
  localparam int CNT_W = 12;

  logic             clk, reset, en, enc_step, enc_dir;
  logic [2:0]       R;
  logic [CNT_W-1:0] amp_limit;
  logic             drive, load, drive_dir, busy;
  logic [CNT_W-1:0] amplitude;
  logic [2:0]       state;

  pendulum_drive_sequencer #(.CNT_W(CNT_W), .TICK_DIV(4), .STALL_MS(8)) dut (
    .clk(clk), .reset(reset), .en(en), .enc_step(enc_step), .enc_dir(enc_dir),
    .R(R), .amp_limit(amp_limit), .drive(drive), .load(load), .drive_dir(drive_dir),
    .amplitude(amplitude), .state(state), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int act_cnt = 0, drv_cnt = 0;
  always @(posedge clk) begin
    if (drive || load) act_cnt <= act_cnt + 1;
    if (drive)         drv_cnt <= drv_cnt + 1;
  end

  typedef struct { string tag; int val; } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int val);
    exp_t e;
    e.tag = tag; e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input int got);
    exp_t e;
    if (sb.size() == 0) chk("sb_empty", 1, 0);
    else begin
      e = sb.pop_front();
      chk(e.tag, got, e.val);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; enc_step = 1'b0; enc_dir = 1'b0;
    R = 3'd0; amp_limit = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic step(input logic d);
    enc_step = 1'b1; enc_dir = d;
    @(negedge clk);
    enc_step = 1'b0;
    @(negedge clk);
  endtask

  task automatic steps(input int n, input logic d);
    for (int i = 0; i < n; i++) step(d);
  endtask

  task automatic wait_win(input int start, output int len);
    for (int i = 0; i < 200 && (drive || load); i++) @(negedge clk);
    if (drive || load) chk("win_timeout", 1, 0);
    len = act_cnt - start;
  endtask

  task automatic arm();
    en = 1'b1;
    @(negedge clk);
  endtask

  int st, st_d, len;

  initial begin
    reset = 1'b1; en = 1'b0; enc_step = 1'b0; enc_dir = 1'b0; R = '0; amp_limit = '0;

    // reset state, then enable
    do_reset();
    push("rst_drive", 0); push("rst_load", 0); push("rst_busy", 0);
    push("rst_dir", 0); push("rst_amp", 0); push("rst_state", 0);
    pop_chk(drive); pop_chk(load); pop_chk(busy);
    pop_chk(drive_dir); pop_chk(amplitude); pop_chk(state);
    push("en_state", 1); push("en_drive", 0);
    arm();
    pop_chk(state); pop_chk(drive);

    // swing to +20, back to 0 with large limit: Drive window
    amp_limit = 100; R = 3'd2;
    steps(20, 1'b1);
    push("amp20", 20);
    step(1'b0);
    pop_chk(amplitude);
    steps(18, 1'b0);
    st = act_cnt;
    push("drv_state", 2); push("drv_on", 1); push("drv_dir", 0);
    push("drv_len", 12); push("drv_cool", 4);
    step(1'b0);
    pop_chk(state); pop_chk(drive); pop_chk(drive_dir);
    wait_win(st, len);
    pop_chk(len); pop_chk(state);

    // same swing, limit at the amplitude: Load window
    do_reset(); arm();
    amp_limit = 20; R = 3'd2;
    steps(20, 1'b1); step(1'b0); steps(18, 1'b0);
    st = act_cnt; st_d = drv_cnt;
    push("ld_state", 3); push("ld_on", 1); push("ld_drive", 0);
    push("ld_len", 12); push("ld_drv_cycles", 0); push("ld_cool", 4); push("ld_rearm", 1);
    step(1'b0);
    pop_chk(state); pop_chk(load); pop_chk(drive);
    wait_win(st, len);
    pop_chk(len); pop_chk(drv_cnt - st_d); pop_chk(state);
    step(1'b1);
    pop_chk(state);

    // stall kick from ARMED clears amplitude
    do_reset(); arm();
    amp_limit = 100; R = 3'd0;
    steps(5, 1'b1);
    push("kick_pre_amp", 5);
    step(1'b0);
    pop_chk(amplitude);
    push("kick_drive", 1); push("kick_dir", 1); push("kick_amp", 0); push("kick_state", 2);
    for (int i = 0; i < 100 && !drive; i++) @(negedge clk);
    pop_chk(drive); pop_chk(drive_dir); pop_chk(amplitude); pop_chk(state);

    // async reset mid-window
    push("rst_async_drive", 0); push("rst_async_state", 0);
    reset = 1'b1;
    #1;
    pop_chk(drive); pop_chk(state);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // second crossing inside a Drive window does not retrigger it
    do_reset(); arm();
    amp_limit = 100; R = 3'd2;
    steps(3, 1'b1); steps(2, 1'b0);
    st = act_cnt;
    push("x2_state", 2); push("x2_len", 12); push("x2_cool", 4);
    step(1'b0);
    pop_chk(state);
    step(1'b1); step(1'b0);
    wait_win(st, len);
    pop_chk(len); pop_chk(state);

    // en drop mid-window
    do_reset(); arm();
    amp_limit = 100; R = 3'd3;
    steps(3, 1'b1); steps(3, 1'b0);
    repeat (3) @(negedge clk);
    push("en_off_state", 0); push("en_off_drive", 0);
    en = 1'b0;
    @(negedge clk);
    pop_chk(state); pop_chk(drive);

    // position wrap and most-negative saturation, stepping in IDLE
    do_reset();
    steps(2048, 1'b0);
    push("amp_sat", 2047);
    step(1'b1);
    pop_chk(amplitude);
    step(1'b0); step(1'b0); step(1'b0);
    push("amp_wrap", 2046); push("wrap_idle", 0);
    step(1'b1);
    pop_chk(amplitude); pop_chk(state);

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
